mul_addshift: RTL and testbench

- Sequential unsigned multiply-add: product = multiplicand*multiplier + addend, radix-2 shift-add, one multiplier bit per clock.
- Inverse of div_subshift with the same start/done handshake. Fed div_subshift's quotient, divisor and remainder, it reconstructs the dividend.
- Used as a standalone multiplier and as the round-trip checker in the arithmetic subsystem.

---
 rtl/arith_pkg.sv | 14 +
 rtl/mul_addshift.sv | 86 ++++++++
 tb/tb_mul_addshift.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and counter sizing for the shift-add/sub arithmetic units.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ADD  = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_addshift.sv
// mul_addshift: sequential unsigned a*b+c, radix-2 shift-add, one multiplier bit per clock.
module mul_addshift
    import arith_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic [DATA_W-1:0]     addend,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CW = cnt_w(DATA_W);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]     a_q, a_d, c_q, c_d, lo_q, lo_d;
    logic [DATA_W:0]       hi_q, hi_d, add_x, add_y, sum;
    logic [2*DATA_W:0]     sh;
    logic [2*DATA_W-1:0]   product_q, product_d;
    logic                  done_q, done_d;

    assign done    = done_q;
    assign product = product_q;

    // One adder serves both phases: hi+a while iterating, lo+c in the ADD cycle.
    always_comb begin
        add_x     = (state_q == BUSY) ? hi_q : {1'b0, lo_q};
        add_y     = (state_q == BUSY) ? (lo_q[0] ? {1'b0, a_q} : '0) : {1'b0, c_q};
        sum       = add_x + add_y;
        sh        = {sum, lo_q} >> 1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        c_d       = c_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        product_d = product_q;
        done_d    = done_q;
        if (state_q == IDLE && start) begin
            a_d     = multiplicand;
            c_d     = addend;
            hi_d    = '0;
            lo_d    = multiplier;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            hi_d    = sh[2*DATA_W:DATA_W];
            lo_d    = sh[DATA_W-1:0];
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(DATA_W - 1)) ? ADD : BUSY;
        end else if (state_q == ADD) begin
            product_d = {hi_q[DATA_W-1:0] + DATA_W'(sum[DATA_W]), sum[DATA_W-1:0]};
            done_d    = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            c_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            c_q       <= c_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_addshift.sv
// tb_mul_addshift: scoreboard bench for mul_addshift at DATA_W=8.
module tb_mul_addshift;

    logic        clk = 1'b0;
    logic        rst, start, done;
    logic [7:0]  multiplicand, multiplier, addend;
    logic [15:0] product;
    logic [15:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    mul_addshift #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .addend(addend), .product(product)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] madd(input logic [7:0] a, b, c);
        return 16'(int'(a) * int'(b) + int'(c));
    endfunction

    // Called at a negedge; returns edges counted from the accepting edge to done, or -1.
    task automatic do_op(input logic [7:0] a, b, c, output int lat);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        sb_q.push_back(madd(a, b, c));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        start = 1'b1;
        multiplicand = 8'd9;
        multiplier = 8'd9;
        addend = 8'd9;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", product); end
        rst = 1'b0;
        start = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_priority: done high %0d cycles, expected 0", bad); end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] exp;
        do_op(8'd13, 8'd11, 8'd5, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== exp || exp !== 16'h0094) begin n_fail++; $display("FAIL basic_product: got %h expected 0094", product); end
    endtask

    task automatic test_max_and_hold();
        int lat;
        int bad;
        logic [15:0] exp;
        do_op(8'd255, 8'd255, 8'd254, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL max_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== exp || exp !== 16'hFEFF) begin n_fail++; $display("FAIL max_product: got %h expected feff", product); end
        multiplicand = 8'd1;
        multiplier = 8'd2;
        addend = 8'd3;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b1 || product !== 16'hFEFF) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hold: %0d cycles lost done/product, expected 0", bad); end
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] exp;
        do_op(8'd0, 8'd200, 8'd0, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL zero_a_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL zero_a_product: got %h expected %h", product, exp); end
        do_op(8'd200, 8'd0, 8'd77, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL zero_b_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== 16'h004D) begin n_fail++; $display("FAIL zero_b_product: got %h expected %h", product, exp); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        int bad;
        logic [15:0] exp;
        multiplicand = 8'd13;
        multiplier = 8'd11;
        addend = 8'd5;
        start = 1'b1;
        sb_q.push_back(madd(8'd13, 8'd11, 8'd5));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = (i == 3);
            multiplicand = 8'(i * 37);
            multiplier = 8'(i * 91);
            addend = 8'(i);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== exp) begin n_fail++; $display("FAIL ignore_product: got %h expected %h", product, exp); end
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (done !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ignore_not_queued: done low %0d cycles, expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic exp_done;
        for (int k = 0; k < 30; k++) begin
            multiplicand = 8'($urandom);
            multiplier = 8'($urandom);
            addend = 8'($urandom);
            start = 1'b1;
            if (k % 10 == 0) sb_q.push_back(madd(multiplicand, multiplier, addend));
            @(posedge clk);
            @(negedge clk);
            exp_done = (k % 10 == 9);
            n_checks++;
            if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, done, exp_done); end
            if (exp_done) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (product !== exp) begin n_fail++; $display("FAIL b2b_product k=%0d: got %h expected %h", k, product, exp); end
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lat;
        int bad;
        logic [15:0] exp;
        multiplicand = 8'd13;
        multiplier = 8'd11;
        addend = 8'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product: got %h expected 0000", product); end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL midrst_discard: done high %0d cycles, expected 0", bad); end
        do_op(8'd3, 8'd4, 8'd1, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL midrst_latency: got %0d expected 10", lat); end
        n_checks++;
        if (product !== 16'd13) begin n_fail++; $display("FAIL midrst_product2: got %h expected %h", product, exp); end
    endtask

    task automatic test_roundtrip();
        int lat;
        int dd, dv, q, r;
        logic [15:0] exp;
        do_op(8'd28, 8'd7, 8'd4, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (product !== 16'd200) begin n_fail++; $display("FAIL rt_200: got %h expected %h", product, exp); end
        for (int i = 0; i < 1000; i++) begin
            dd = int'($urandom_range(0, 255));
            dv = int'($urandom_range(1, 255));
            q = dd / dv;
            r = dd % dv;
            do_op(8'(q), 8'(dv), 8'(r), lat);
            exp = sb_q.pop_front();
            n_checks++;
            if (lat !== 10 || product !== 16'(dd)) begin
                n_fail++;
                $display("FAIL rt_rand %0d/%0d: got %h lat %0d expected %h lat 10", dd, dv, product, lat, 16'(dd));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_max_and_hold();
        test_zero();
        test_mid_reset();
        test_ignore_busy();
        test_back_to_back();
        test_roundtrip();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
